// File: rtl/local_store_responder_if.sv
// -----------------------------------------------------------------------------
// local_store_responder_if
//   Bundles the data-port and fetch-port signals of the local store.
//   master : requester side (odd pipe / fetch stage, or a testbench)
//   slave  : the local store itself
//
//   Data port : ls_req_valid, ls_wr_en, ls_addr, ls_wr_data  (master -> slave)
//               ls_rd_data, ls_rd_valid, ls_ready            (slave -> master)
//   Fetch port: if_req_valid, if_addr                        (master -> slave)
//               if_rd_data, if_rd_valid                      (slave -> master)
// -----------------------------------------------------------------------------
interface local_store_responder_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 128
);
  logic              ls_req_valid;
  logic              ls_wr_en;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wr_data;
  logic [DATA_W-1:0] ls_rd_data;
  logic              ls_rd_valid;
  logic              ls_ready;

  logic              if_req_valid;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rd_data;
  logic              if_rd_valid;

  modport master (
    output ls_req_valid, ls_wr_en, ls_addr, ls_wr_data, if_req_valid, if_addr,
    input  ls_rd_data, ls_rd_valid, ls_ready, if_rd_data, if_rd_valid
  );

  modport slave (
    input  ls_req_valid, ls_wr_en, ls_addr, ls_wr_data, if_req_valid, if_addr,
    output ls_rd_data, ls_rd_valid, ls_ready, if_rd_data, if_rd_valid
  );
endinterface

// File: rtl/local_store_responder.sv
// -----------------------------------------------------------------------------
// local_store_responder
//   32 KB local store organised as 2048 quadword lines of 128 bits.
//   A fully pipelined data port (one load or store per cycle, fixed read
//   latency RD_LAT) and an independent read-only fetch port with the same
//   latency. After reset an init state machine optionally zero-fills every
//   line; requests are only accepted once ls_ready is high.
//
//   Ports:
//     clock  : clock
//     reset  : synchronous, active-high reset
//     bus    : local_store_responder_if.slave (data port, fetch port, ls_ready)
// -----------------------------------------------------------------------------
module local_store_responder #(
  parameter int ADDR_W         = 15,
  parameter int DATA_W         = 128,
  parameter int RD_LAT         = 6,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                     clock,
  input  logic                     reset,
  local_store_responder_if.slave   bus
);

  localparam int LINE_W = ADDR_W - 4;
  localparam int DEPTH  = 1 << LINE_W;

  typedef enum logic [1:0] {
    RESET_HOLD,
    INIT,
    READY
  } state_t;

  state_t              r_state;
  state_t              w_stateNext;
  logic [LINE_W-1:0]   r_initCount;
  logic [LINE_W-1:0]   w_initCountNext;
  logic                w_initWrite;
  logic                w_ready;

  logic                w_lsAccept;
  logic                w_lsLoad;
  logic                w_lsStore;
  logic                w_ifAccept;
  logic [LINE_W-1:0]   w_lsLine;
  logic [LINE_W-1:0]   w_ifLine;

  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic [RD_LAT-1:0]   r_lsValidPipe;
  logic [DATA_W-1:0]   r_lsDataPipe [RD_LAT];
  logic [RD_LAT-1:0]   r_ifValidPipe;
  logic [DATA_W-1:0]   r_ifDataPipe [RD_LAT];

  // Byte address to line index: the low four bits select a byte inside the
  // quadword and play no part in line selection.
  assign w_lsLine = bus.ls_addr[ADDR_W-1:4];
  assign w_ifLine = bus.if_addr[ADDR_W-1:4];

  assign w_ready    = (r_state == READY);
  assign w_lsAccept = w_ready && bus.ls_req_valid;
  assign w_lsLoad   = w_lsAccept && !bus.ls_wr_en;
  assign w_lsStore  = w_lsAccept &&  bus.ls_wr_en;
  assign w_ifAccept = w_ready && bus.if_req_valid;

  // State and init-counter registers. Reset always parks the machine in
  // RESET_HOLD with the counter at line 0, so an interrupted init restarts.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= RESET_HOLD;
      r_initCount <= '0;
    end else begin
      r_state     <= w_stateNext;
      r_initCount <= w_initCountNext;
    end
  end

  // Next-state logic. INIT clears one line per cycle and hands over to READY
  // on the same edge that clears the last line.
  always_comb begin
    w_stateNext     = r_state;
    w_initCountNext = r_initCount;
    w_initWrite     = 1'b0;
    unique case (r_state)
      RESET_HOLD: begin
        if (CLEAR_ON_RESET) begin
          w_stateNext = INIT;
        end else begin
          w_stateNext = READY;
        end
      end
      INIT: begin
        w_initWrite     = 1'b1;
        w_initCountNext = r_initCount + 1'b1;
        if (r_initCount == LINE_W'(DEPTH - 1)) begin
          w_stateNext = READY;
        end
      end
      READY: begin
        w_stateNext = READY;
      end
      default: begin
        w_stateNext = RESET_HOLD;
      end
    endcase
  end

  // Array write port. Init and stores are mutually exclusive because stores
  // are only accepted in READY. Nothing is written on an edge where reset is
  // sampled high.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (w_initWrite) begin
        r_mem[r_initCount] <= '0;
      end else if (w_lsStore) begin
        r_mem[w_lsLine] <= bus.ls_wr_data;
      end
    end
  end

  // Data-port read pipeline. The array is read on the accepting edge, so a
  // load one cycle after a store already sees the new line. Stores enter as
  // bubbles; bubble slots carry zero data so idle outputs read as zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_lsValidPipe <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        r_lsDataPipe[i] <= '0;
      end
    end else begin
      r_lsValidPipe[0] <= w_lsLoad;
      r_lsDataPipe[0]  <= w_lsLoad ? r_mem[w_lsLine] : '0;
      for (int i = 1; i < RD_LAT; i++) begin
        r_lsValidPipe[i] <= r_lsValidPipe[i-1];
        r_lsDataPipe[i]  <= r_lsDataPipe[i-1];
      end
    end
  end

  // Fetch read pipeline. A fetch on the same edge as a store to the same
  // line reads the array before the store lands and returns the old data.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_ifValidPipe <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        r_ifDataPipe[i] <= '0;
      end
    end else begin
      r_ifValidPipe[0] <= w_ifAccept;
      r_ifDataPipe[0]  <= w_ifAccept ? r_mem[w_ifLine] : '0;
      for (int i = 1; i < RD_LAT; i++) begin
        r_ifValidPipe[i] <= r_ifValidPipe[i-1];
        r_ifDataPipe[i]  <= r_ifDataPipe[i-1];
      end
    end
  end

  assign bus.ls_ready    = w_ready;
  assign bus.ls_rd_valid = r_lsValidPipe[RD_LAT-1];
  assign bus.ls_rd_data  = r_lsDataPipe[RD_LAT-1];
  assign bus.if_rd_valid = r_ifValidPipe[RD_LAT-1];
  assign bus.if_rd_data  = r_ifDataPipe[RD_LAT-1];

endmodule

// File: tb/tb_local_store_responder.sv
// -----------------------------------------------------------------------------
// tb_local_store_responder
//   Self-checking bench for local_store_responder. A behavioural model keeps
//   the store contents in a plain array and expected responses in queues
//   tagged with the cycle they are due; every cycle the DUT outputs are
//   compared against it. Directed tables and sequences cover init, round
//   trip, back-to-back traffic, same-cycle conflict, reset mid-flight and an
//   RD_LAT=1 build.
// -----------------------------------------------------------------------------
module tb_local_store_responder;

  localparam int RD_LAT     = 6;
  localparam int INIT_EDGES = 2049;

  typedef struct {
    longint       due;
    logic [127:0] data;
  } resp_t;

  typedef struct {
    bit           wr;
    logic [14:0]  addr;
    logic [127:0] wdata;
    logic [127:0] expData;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b1;

  local_store_responder_if bus0 ();
  local_store_responder_if bus1 ();

  local_store_responder dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus0)
  );

  local_store_responder #(
    .RD_LAT         (1),
    .CLEAR_ON_RESET (1'b0)
  ) dutLat1 (
    .clock (clock),
    .reset (reset),
    .bus   (bus1)
  );

  always #5 clock = ~clock;

  int           checks   = 0;
  int           failures = 0;
  bit           checkEn  = 1'b0;

  logic [127:0] modelMem [2048];
  bit           modelReady = 1'b0;
  int           lowEdges   = 0;
  longint       edgeCount  = 0;
  resp_t        lsQ[$];
  resp_t        ifQ[$];
  logic [127:0] obsLs[$];
  logic [127:0] obsIf[$];

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Drive one cycle of requests on the main DUT; they are sampled at the next
  // rising edge, after which the valids drop back to idle.
  task automatic applyStimulus(input bit lsValid, input bit wr,
                               input logic [14:0] addr, input logic [127:0] wdata,
                               input bit ifValid, input logic [14:0] ifAddr);
    bus0.ls_req_valid = lsValid;
    bus0.ls_wr_en     = wr;
    bus0.ls_addr      = addr;
    bus0.ls_wr_data   = wdata;
    bus0.if_req_valid = ifValid;
    bus0.if_addr      = ifAddr;
    @(posedge clock);
    #1;
    bus0.ls_req_valid = 1'b0;
    bus0.if_req_valid = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'b0, 15'h0, 128'h0, 1'b0, 15'h0);
    end
  endtask

  task automatic waitReady(input int expected);
    int cnt  = 0;
    bit seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clock);
      if (bus0.ls_ready) seen = 1'b1;
      else cnt++;
    end
    if (!seen) checkOutput("ready_timeout", 128'(bus0.ls_ready), 128'd1);
    else checkOutput("init_cycles", 128'(cnt), 128'(expected));
    @(posedge clock);
    #1;
  endtask

  // Reference model, updated at every rising edge from the inputs the DUT
  // samples there. Reads happen before the store of the same edge lands.
  initial begin
    int           line;
    bit           doStore;
    int           storeLine;
    logic [127:0] storeData;
    forever begin
      @(posedge clock);
      if (reset) begin
        lsQ.delete();
        ifQ.delete();
        modelReady = 1'b0;
        lowEdges   = 0;
      end else begin
        doStore = 1'b0;
        if (modelReady && bus0.ls_req_valid) begin
          line = int'(bus0.ls_addr) / 16;
          if (bus0.ls_wr_en) begin
            doStore   = 1'b1;
            storeLine = line;
            storeData = bus0.ls_wr_data;
          end else begin
            lsQ.push_back('{edgeCount + RD_LAT, modelMem[line]});
          end
        end
        if (modelReady && bus0.if_req_valid) begin
          ifQ.push_back('{edgeCount + RD_LAT, modelMem[int'(bus0.if_addr) / 16]});
        end
        if (doStore) modelMem[storeLine] = storeData;
        lowEdges++;
        if (lowEdges == INIT_EDGES) begin
          modelReady = 1'b1;
          foreach (modelMem[i]) modelMem[i] = '0;
        end
      end
      edgeCount++;
    end
  end

  // Per-cycle comparison on the falling edge.
  initial begin
    bit           expV;
    logic [127:0] expD;
    forever begin
      @(negedge clock);
      if (checkEn) begin
        checkOutput("ls_ready", 128'(bus0.ls_ready), 128'(modelReady));

        expV = 1'b0;
        expD = '0;
        if (lsQ.size() > 0 && lsQ[0].due == edgeCount) begin
          expV = 1'b1;
          expD = lsQ[0].data;
          lsQ.delete(0);
        end
        checkOutput("ls_rd_valid", 128'(bus0.ls_rd_valid), 128'(expV));
        checkOutput("ls_rd_data", bus0.ls_rd_data, expD);

        expV = 1'b0;
        expD = '0;
        if (ifQ.size() > 0 && ifQ[0].due == edgeCount) begin
          expV = 1'b1;
          expD = ifQ[0].data;
          ifQ.delete(0);
        end
        checkOutput("if_rd_valid", 128'(bus0.if_rd_valid), 128'(expV));
        checkOutput("if_rd_data", bus0.if_rd_data, expD);

        if (bus0.ls_rd_valid) obsLs.push_back(bus0.ls_rd_data);
        if (bus0.if_rd_valid) obsIf.push_back(bus0.if_rd_data);
      end
    end
  end

  initial begin
    vec_t         vecs [16];
    logic [127:0] rtData;
    logic [127:0] d;
    logic [14:0]  a;
    logic [14:0]  fa;

    // Back-to-back table: stores of i to lines 0..7, then loads of the same
    // lines with nonzero byte offsets that must be ignored.
    for (int i = 0; i < 8; i++) begin
      vecs[i]     = '{1'b1, 15'(i * 16), 128'(i), 128'h0};
      vecs[i + 8] = '{1'b0, 15'(i * 16 + 4'hF - i), 128'h0, 128'(i)};
    end

    bus0.ls_req_valid = 1'b0;
    bus0.ls_wr_en     = 1'b0;
    bus0.ls_addr      = '0;
    bus0.ls_wr_data   = '0;
    bus0.if_req_valid = 1'b0;
    bus0.if_addr      = '0;
    bus1.ls_req_valid = 1'b0;
    bus1.ls_wr_en     = 1'b0;
    bus1.ls_addr      = '0;
    bus1.ls_wr_data   = '0;
    bus1.if_req_valid = 1'b0;
    bus1.if_addr      = '0;

    // Init: reset for 3 cycles, release, interrupt the init, then let it run.
    @(posedge clock);
    #1;
    checkEn = 1'b1;
    @(posedge clock);
    #1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    idleCycles(100);
    reset = 1'b1;
    idleCycles(2);
    reset = 1'b0;
    idleCycles(3);
    applyStimulus(1'b1, 1'b1, 15'h0100, {16{8'hAA}}, 1'b0, 15'h0);
    idleCycles(7);
    waitReady(INIT_EDGES - 11);

    obsLs.delete();
    applyStimulus(1'b1, 1'b0, 15'h0050, 128'h0, 1'b0, 15'h0);
    applyStimulus(1'b1, 1'b0, 15'h0100, 128'h0, 1'b0, 15'h0);
    idleCycles(RD_LAT + 2);
    checkOutput("init_load_count", 128'(obsLs.size()), 128'd2);
    for (int i = 0; i < obsLs.size(); i++) checkOutput("init_load_zero", obsLs[i], 128'h0);

    // Store/load round trip with exact latency.
    rtData = 128'h0123456789ABCDEF_FEDCBA9876543210;
    applyStimulus(1'b1, 1'b1, 15'h1230, rtData, 1'b0, 15'h0);
    applyStimulus(1'b1, 1'b0, 15'h123C, 128'h0, 1'b0, 15'h0);
    for (int i = 1; i <= RD_LAT; i++) begin
      @(negedge clock);
      checkOutput("rt_valid_timing", 128'(bus0.ls_rd_valid), 128'(i == RD_LAT));
    end
    checkOutput("rt_data", bus0.ls_rd_data, rtData);
    @(posedge clock);
    #1;

    // Back-to-back table.
    obsLs.delete();
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, vecs[i].wr, vecs[i].addr, vecs[i].wdata, 1'b0, 15'h0);
    end
    idleCycles(RD_LAT + 2);
    checkOutput("b2b_count", 128'(obsLs.size()), 128'd8);
    for (int i = 0; i < 8 && i < obsLs.size(); i++) begin
      checkOutput("b2b_data", obsLs[i], vecs[i + 8].expData);
    end

    // Same-cycle store and fetch on line 2047.
    obsIf.delete();
    applyStimulus(1'b1, 1'b1, 15'h7FFF, {16{8'h11}}, 1'b0, 15'h0);
    applyStimulus(1'b1, 1'b1, 15'h7FF0, {16{8'h22}}, 1'b1, 15'h7FF8);
    applyStimulus(1'b0, 1'b0, 15'h0, 128'h0, 1'b1, 15'h7FF8);
    idleCycles(RD_LAT + 2);
    checkOutput("conflict_count", 128'(obsIf.size()), 128'd2);
    if (obsIf.size() >= 2) begin
      checkOutput("conflict_old", obsIf[0], {16{8'h11}});
      checkOutput("conflict_new", obsIf[1], {16{8'h22}});
    end

    // Randomized traffic; unqualified inputs carry junk.
    for (int c = 0; c < 400; c++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 1) == 1) a = 15'($urandom_range(0, 15) * 16 + $urandom_range(0, 15));
      else a = 15'($urandom);
      fa = 15'($urandom_range(0, 15) * 16 + $urandom_range(0, 15));
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, a, d,
                    $urandom_range(0, 1) == 1, fa);
    end
    idleCycles(RD_LAT + 2);

    // Reset mid-flight: three loads, reset sampled with the third.
    obsLs.delete();
    applyStimulus(1'b1, 1'b0, 15'h0000, 128'h0, 1'b0, 15'h0);
    applyStimulus(1'b1, 1'b0, 15'h0010, 128'h0, 1'b0, 15'h0);
    reset = 1'b1;
    applyStimulus(1'b1, 1'b0, 15'h0020, 128'h0, 1'b0, 15'h0);
    reset = 1'b0;
    checkOutput("reset_ready_drop", 128'(bus0.ls_ready), 128'd0);
    waitReady(INIT_EDGES);
    checkOutput("reset_no_valid", 128'(obsLs.size()), 128'd0);
    applyStimulus(1'b1, 1'b0, 15'h0030, 128'h0, 1'b0, 15'h0);
    idleCycles(RD_LAT + 2);
    checkOutput("reset_reload_count", 128'(obsLs.size()), 128'd1);
    if (obsLs.size() >= 1) checkOutput("reset_reload_zero", obsLs[0], 128'h0);

    // RD_LAT=1 build without clear-on-reset.
    checkOutput("lat1_ready", 128'(bus1.ls_ready), 128'd1);
    d = {4{32'hC0DE_5A5A}};
    bus1.ls_req_valid = 1'b1;
    bus1.ls_wr_en     = 1'b1;
    bus1.ls_addr      = 15'h0400;
    bus1.ls_wr_data   = d;
    @(posedge clock);
    #1;
    bus1.ls_wr_en = 1'b0;
    bus1.ls_addr  = 15'h0407;
    @(negedge clock);
    checkOutput("lat1_store_no_valid", 128'(bus1.ls_rd_valid), 128'd0);
    @(posedge clock);
    #1;
    bus1.ls_req_valid = 1'b0;
    @(negedge clock);
    checkOutput("lat1_valid", 128'(bus1.ls_rd_valid), 128'd1);
    checkOutput("lat1_data", bus1.ls_rd_data, d);
    @(negedge clock);
    checkOutput("lat1_idle_valid", 128'(bus1.ls_rd_valid), 128'd0);
    checkOutput("lat1_idle_data", bus1.ls_rd_data, 128'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
